// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator datapath blocks.
package acc_pkg;

    // Default datapath width of samples and deltas.
    localparam int unsigned ACC_WIDTH = 32;

    // Occupancy of the 2-entry output skid buffer. The encoding is the entry count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // One buffered delta at the default width.
    typedef struct packed {
        logic [ACC_WIDTH-1:0] data;
        logic                 wrap;
    } acc_delta_t;

    // Number of valid entries held in a given buffer state.
    function automatic logic [1:0] buf_count(buf_state_e st);
        unique case (st)
            BUF_EMPTY: buf_count = 2'd0;
            BUF_ONE:   buf_count = 2'd1;
            BUF_TWO:   buf_count = 2'd2;
            default:   buf_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/acc_diff_if.sv
// Sample-in / delta-out handshake bundle for acc_diff.
interface acc_diff_if #(
    parameter int unsigned WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic             in_ready;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             wrap;

    // Producer of samples and consumer of deltas (the environment).
    modport master (
        output enable,
        output data_in,
        output clear,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out,
        input  wrap
    );

    // The acc_diff block itself.
    modport slave (
        input  enable,
        input  data_in,
        input  clear,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out,
        output wrap
    );
endinterface

// File: rtl/acc_diff_sub.sv
// Combinational subtractor a - b computed as a + ~b + 1 on a Kogge-Stone
// carry-lookahead adder. borrow_o is set when a < b (unsigned).
module acc_diff_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int unsigned Levels = (WIDTH > 1) ? $clog2(WIDTH) : 0;

    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] gk;
    logic [WIDTH-1:0] pk;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    logic [WIDTH:0]   carry;

    assign b_n = ~b_i;

    // Prefix tree: after the last level gk[i] is the carry out of bit i.
    always_comb begin
        prop = a_i ^ b_n;
        gen  = a_i & b_n;
        gk   = gen;
        pk   = prop;
        gn   = '0;
        pn   = '0;
        // The +1 is a carry-in of 1, folded into the bit-0 group generate.
        gk[0] = gen[0] | prop[0];
        for (int l = 0; l < int'(Levels); l++) begin
            gn = gk;
            pn = pk;
            for (int i = (1 << l); i < int'(WIDTH); i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
                pn[i] = pk[i] & pk[i - (1 << l)];
            end
            gk = gn;
            pk = pn;
        end
        carry    = {gk, 1'b1};
        diff_o   = prop ^ carry[WIDTH-1:0];
        borrow_o = ~carry[WIDTH];
    end

endmodule

// File: rtl/acc_diff.sv
// Accumulator inverse: turns a stream of running sums back into per-step
// increments (sample - previous sample), with a 2-entry output skid buffer.
module acc_diff
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = ACC_WIDTH
) (
    input logic        clk,
    input logic        reset,
    acc_diff_if.slave  bus
);

    // Width-parameterised form of acc_delta_t.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             wrap;
    } entry_t;

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;

    logic [WIDTH-1:0] diff;
    logic             borrow;
    entry_t           new_entry;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             pop;

    acc_diff_sub #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i      (bus.data_in),
        .b_i      (prev_q),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    assign new_entry = '{data: diff, wrap: borrow};

    // Ready depends only on registered state, clear and reset; never on out_ready.
    assign in_ready  = (state_q != BUF_TWO) && !bus.clear && reset;
    assign out_valid = (buf_count(state_q) != 2'd0);
    assign accept    = bus.enable && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.data_out  = head_q.data;
    assign bus.wrap      = head_q.wrap;

    // Next-state for the buffer occupancy, entries and previous sample.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (bus.clear) begin
            state_d = BUF_EMPTY;
            prev_d  = '0;
        end else begin
            if (accept) begin
                prev_d = bus.data_in;
            end
            unique case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d = BUF_ONE;
                        head_d  = new_entry;
                    end
                end
                BUF_ONE: begin
                    if (accept && pop) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        state_d = BUF_TWO;
                        tail_d  = new_entry;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d = BUF_ONE;
                        head_d  = tail_q;
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BUF_EMPTY;
            prev_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: doc/acc_diff.md
Name: acc_diff

Overview:
- Inverse of the `acc` running-sum accumulator: consumes a stream of accumulated values and emits the per-step increments, `delta = sample - previous sample`.
- Sits downstream of `acc` `data_out`, or on any cumulative counter, to recover the original increments.
- Used as the reader/checker end of the accumulator datapath in the adder lab flow.
- The subtraction uses the team's adder structure (`a + ~b + 1`). A 2-entry output skid buffer decouples input and output handshakes.

Parameters:
- WIDTH, 32, datapath width of samples and deltas.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; reset==0 at a clk edge resets the block.
- enable  input  1  input valid; a sample is accepted when enable && in_ready.
- data_in  input  WIDTH  accumulated sample.
- in_ready  output  1  block can accept a sample this cycle.
- clear  input  1  synchronous: forces previous-sample register to 0 and flushes the buffer.
- out_valid  output  1  data_out/wrap hold a valid delta.
- out_ready  input  1  consumer takes the delta when out_valid && out_ready.
- data_out  output  WIDTH  delta, modulo 2^WIDTH.
- wrap  output  1  borrow occurred: data_in < previous, unsigned, i.e. the accumulator wrapped.

Behaviour:
- Reset (reset==0 at edge):
  - prev=0, buffer count=0, out_valid=0, data_out=0, wrap=0.
  - in_ready=0 while reset is low; 1 from the first cycle after release.
- prev register:
  - Reset value 0 matches `acc` reset, so the first delta equals the first sample.
  - On accept, prev <= data_in.
- Delta: {borrow_n, diff} = data_in + ~prev + 1 at WIDTH+1 bits. data_out = diff[WIDTH-1:0]; wrap = ~carry_out. No saturation.
- Buffer FSM states (count):
  - EMPTY (0): in_ready=1, out_valid=0. Accept -> ONE; entry visible on data_out the next cycle (latency 1).
  - ONE (1): in_ready=1, out_valid=1.
    - Accept and pop -> stay ONE, head replaced.
    - Accept only -> TWO.
    - Pop only -> EMPTY.
  - TWO (2): in_ready=0, out_valid=1. Pop -> ONE; second entry moves to head.
- in_ready = (count!=2) && !clear && reset.
- Registered outputs: data_out and wrap are taken directly from the head entry. They are stable while out_valid && !out_ready.
- Held input: enable=0 means no accept; prev is unchanged and no delta is produced. A repeated equal sample with enable=1 yields delta 0, wrap=0.
- clear:
  - Priority over accept and pop in the same cycle.
  - prev <= 0, count <= 0, out_valid <= 0 next cycle. The sample presented that cycle is not accepted (in_ready=0).
- Reset mid-operation: all buffered deltas are discarded, prev=0, same as the reset values above; no partial outputs.
- No combinational path from out_ready to in_ready.

Decomposition:
- Package acc_pkg:
  - ACC_WIDTH default (32).
  - Buffer-state enum {BUF_EMPTY, BUF_ONE, BUF_TWO}.
  - Delta entry struct {data[WIDTH], wrap}.
- Sub-module acc_diff_sub:
  - Combinational WIDTH-bit subtractor, a + ~b + 1, built on the team's CLA adder.
  - Outputs diff and borrow.
  - Reused later by other inverse blocks.

Test Plan:
- Accumulator inverse: after reset, enable samples 0x10, 0x15, 0x3C, 0x6C on consecutive cycles, out_ready=1 -> data_out 0x10, 0x05, 0x27, 0x30 one cycle after each accept, wrap=0.
- Backpressure: out_ready=0, push 0x10, 0x20, 0x25 -> in_ready drops after 2 accepts; data_out holds 0x10. Raise out_ready -> 0x10, 0x10, 0x05 in order; nothing lost or duplicated.
- Wrap: push 0xFFFFFFF0, then 0x00000010 -> deltas 0xFFFFFFF0 (wrap=0), then 0x00000020 (wrap=1).
- Clear collision: buffer holds 2 entries, prev=0x40; assert clear with enable=1, data_in=0x50 -> next cycle out_valid=0, sample not accepted. Then push 0x08 -> delta 0x08.
- Reset mid-stream: reset=0 for one cycle while TWO -> out_valid=0, data_out=0, in_ready=0 during reset. Next sample 0x33 -> delta 0x33.
- Hold and repeat: enable low for 5 cycles -> no out_valid. Same value pushed twice -> second delta 0, wrap=0.
